// File: rtl/taillight_pkg.sv
// Shared constants, tracker state encoding and error-code helpers for the taillight decoder.
package taillight_pkg;

  localparam int unsigned PAT_W = 3;
  localparam int unsigned ERR_W = 3;

  // Lamp patterns that can appear on a side bus
  localparam logic [PAT_W-1:0] P_OFF = 3'b000;
  localparam logic [PAT_W-1:0] P_001 = 3'b001;
  localparam logic [PAT_W-1:0] P_011 = 3'b011;
  localparam logic [PAT_W-1:0] P_111 = 3'b111;
  localparam logic [PAT_W-1:0] P_110 = 3'b110;
  localparam logic [PAT_W-1:0] P_100 = 3'b100;

  // Violation codes; lower value has higher priority
  localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 3'd1;
  localparam logic [ERR_W-1:0] ERR_ORDER   = 3'd2;
  localparam logic [ERR_W-1:0] ERR_SHORT   = 3'd3;
  localparam logic [ERR_W-1:0] ERR_LONG    = 3'd4;
  localparam logic [ERR_W-1:0] ERR_CROSS   = 3'd5;

  typedef enum logic [3:0] {
    S_OFF = 4'd0,
    S_ON  = 4'd1,
    S_T1  = 4'd2,
    S_T2  = 4'd3,
    S_T3  = 4'd4,
    S_T4  = 4'd5,
    S_B2  = 4'd6,
    S_B3  = 4'd7,
    S_B4  = 4'd8,
    S_BAD = 4'd9
  } trk_state_e;

  // True for any of the six patterns the controller can legally emit
  function automatic logic is_legal(input logic [PAT_W-1:0] pat);
    return (pat == P_OFF) || (pat == P_001) || (pat == P_011) ||
           (pat == P_111) || (pat == P_110) || (pat == P_100);
  endfunction

  // Code for an unexpected pattern change
  function automatic logic [ERR_W-1:0] change_code(input logic [PAT_W-1:0] pat);
    return is_legal(pat) ? ERR_ORDER : ERR_ILLEGAL;
  endfunction

  // Highest-priority (lowest non-zero) of two codes
  function automatic logic [ERR_W-1:0] min_code(input logic [ERR_W-1:0] a,
                                                input logic [ERR_W-1:0] b);
    if (a == ERR_NONE) return b;
    if (b == ERR_NONE) return a;
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/taillight_side_tracker.sv
// Per-side lamp pattern tracker: follows the turn/brake sequence and times each phase.
module taillight_side_tracker
  import taillight_pkg::*;
#(
  parameter int unsigned DWELL = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] pat,
  output logic             turn_c,
  output logic             brk_c,
  output logic [ERR_W-1:0] err_code_c
);

  localparam int unsigned DW = $clog2(DWELL + 2);

  trk_state_e       state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [ERR_W-1:0] code;
  logic [PAT_W-1:0] cur_pat, nxt_pat;
  trk_state_e       nxt_st;

  // Next-state, phase timing and violation detection for one side
  always_comb begin
    state_d = state_q;
    code    = ERR_NONE;
    cur_pat = P_OFF;
    nxt_pat = P_OFF;
    nxt_st  = S_OFF;

    unique case (state_q)
      S_T1: begin cur_pat = P_001; nxt_pat = P_011; nxt_st = S_T2; end
      S_T2: begin cur_pat = P_011; nxt_pat = P_111; nxt_st = S_T3; end
      S_B2: begin cur_pat = P_110; nxt_pat = P_100; nxt_st = S_B3; end
      S_B3: begin cur_pat = P_100; nxt_pat = P_OFF; nxt_st = S_B4; end
      default: ;
    endcase

    unique case (state_q)
      S_OFF: begin
        if (pat == P_001)      state_d = S_T1;
        else if (pat == P_111) state_d = S_ON;
        else if (pat != P_OFF) code = change_code(pat);
      end
      S_ON: begin
        if (pat == P_OFF) state_d = S_OFF;
        else if (pat == P_110) begin
          if (dwell_q >= DW'(DWELL)) state_d = S_B2;
          else                       code = ERR_SHORT;
        end
        else if (pat != P_111) code = change_code(pat);
      end
      // Timed phases: advance only at exactly DWELL, error if held too long
      S_T1, S_T2, S_B2, S_B3: begin
        if (pat == cur_pat) begin
          if (dwell_q >= DW'(DWELL)) code = ERR_LONG;
        end
        else if ((pat == nxt_pat) && (dwell_q == DW'(DWELL))) state_d = nxt_st;
        else if (pat == P_OFF) state_d = S_OFF;
        else if (pat == P_111) state_d = S_ON;
        else if (pat == nxt_pat) code = ERR_SHORT;
        else code = change_code(pat);
      end
      S_T3: begin
        if (pat == P_OFF) state_d = (dwell_q == DW'(DWELL)) ? S_T4 : S_OFF;
        else if (pat != P_111) code = change_code(pat);
      end
      S_T4: begin
        if (pat == P_OFF) begin
          if (dwell_q >= DW'(DWELL)) state_d = S_OFF;
        end
        else if (pat == P_001) begin
          if (dwell_q == DW'(DWELL)) state_d = S_T1;
          else                       code = ERR_SHORT;
        end
        else if (pat == P_111) state_d = S_ON;
        else code = change_code(pat);
      end
      S_B4: begin
        if (pat == P_OFF) begin
          if (dwell_q >= DW'(DWELL)) state_d = S_OFF;
        end
        else if (pat == P_111) state_d = S_ON;
        else code = change_code(pat);
      end
      S_BAD: begin
        if (pat == P_OFF)      state_d = S_OFF;
        else if (pat == P_111) state_d = S_ON;
        else if (!is_legal(pat)) code = ERR_ILLEGAL;
      end
      default: state_d = S_BAD;
    endcase

    // Resync after a violation
    if (code != ERR_NONE) begin
      if (pat == P_OFF)      state_d = S_OFF;
      else if (pat == P_111) state_d = S_ON;
      else                   state_d = S_BAD;
    end

    if (state_d != state_q) dwell_d = DW'(1);
    else if (dwell_q >= DW'(DWELL + 1)) dwell_d = dwell_q;
    else dwell_d = dwell_q + DW'(1);
  end

  // Tracker state and dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  // Decoded command for the upcoming state, registered by the parent
  always_comb begin
    turn_c = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_T3) ||
             (state_d == S_T4) || (state_d == S_B2) || (state_d == S_B3) ||
             (state_d == S_B4);
    brk_c  = (state_d == S_B2) || (state_d == S_B3) || (state_d == S_B4) ||
             ((state_d == S_ON) && (dwell_d == DW'(DWELL + 1)));
    err_code_c = code;
  end

endmodule

// File: rtl/taillight_pattern_decoder.sv
// Lamp-side decoder: reconstructs turn/brake commands and flags protocol violations.
module taillight_pattern_decoder
  import taillight_pkg::*;
#(
  parameter int unsigned DWELL = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] left_taillight_control,
  input  logic [PAT_W-1:0] right_taillight_control,
  input  logic             err_clr,
  output logic             turn_left_det,
  output logic             turn_right_det,
  output logic             brake_det,
  output logic             seq_error,
  output logic [ERR_W-1:0] err_code
);

  logic             l_turn_c, r_turn_c, l_brk_c, r_brk_c;
  logic [ERR_W-1:0] l_code_c, r_code_c, new_code;
  logic             turn_left_det_q, turn_left_det_d;
  logic             turn_right_det_q, turn_right_det_d;
  logic             brake_det_q, brake_det_d;
  logic             seq_error_q, seq_error_d;
  logic [ERR_W-1:0] err_code_q, err_code_d;

  taillight_side_tracker #(.DWELL(DWELL)) u_left (
    .clk        (clk),
    .rst_n      (rst_n),
    .pat        (left_taillight_control),
    .turn_c     (l_turn_c),
    .brk_c      (l_brk_c),
    .err_code_c (l_code_c)
  );

  taillight_side_tracker #(.DWELL(DWELL)) u_right (
    .clk        (clk),
    .rst_n      (rst_n),
    .pat        (right_taillight_control),
    .turn_c     (r_turn_c),
    .brk_c      (r_brk_c),
    .err_code_c (r_code_c)
  );

  // Output decode, cross-check and sticky first-error capture
  always_comb begin
    turn_left_det_d  = l_turn_c;
    turn_right_det_d = r_turn_c;
    brake_det_d      = l_brk_c | r_brk_c;
    seq_error_d      = seq_error_q;
    err_code_d       = err_code_q;
    new_code = min_code(min_code(l_code_c, r_code_c),
                        (l_turn_c & r_turn_c) ? ERR_CROSS : ERR_NONE);
    if (new_code != ERR_NONE) begin
      seq_error_d = 1'b1;
      if (!seq_error_q || err_clr) err_code_d = new_code;
    end else if (err_clr) begin
      seq_error_d = 1'b0;
      err_code_d  = ERR_NONE;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_left_det_q  <= 1'b0;
      turn_right_det_q <= 1'b0;
      brake_det_q      <= 1'b0;
      seq_error_q      <= 1'b0;
      err_code_q       <= ERR_NONE;
    end else begin
      turn_left_det_q  <= turn_left_det_d;
      turn_right_det_q <= turn_right_det_d;
      brake_det_q      <= brake_det_d;
      seq_error_q      <= seq_error_d;
      err_code_q       <= err_code_d;
    end
  end

  assign turn_left_det  = turn_left_det_q;
  assign turn_right_det = turn_right_det_q;
  assign brake_det      = brake_det_q;
  assign seq_error      = seq_error_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_taillight_pattern_decoder.sv
// Directed-vector bench for taillight_pattern_decoder.
module tb_taillight_pattern_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] left_p = 3'b000;
  logic [2:0] right_p = 3'b000;
  logic       err_clr = 1'b0;
  logic       turn_left_det, turn_right_det, brake_det, seq_error;
  logic [2:0] err_code;

  int total = 0;
  int bad = 0;

  taillight_pattern_decoder dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .left_taillight_control  (left_p),
    .right_taillight_control (right_p),
    .err_clr                 (err_clr),
    .turn_left_det           (turn_left_det),
    .turn_right_det          (turn_right_det),
    .brake_det               (brake_det),
    .seq_error               (seq_error),
    .err_code                (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got={tl,tr,br,se,ec}=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic tl, input logic tr,
                             input logic br, input logic se, input logic [2:0] ec);
    check(tag, {turn_left_det, turn_right_det, brake_det, seq_error, err_code},
          {tl, tr, br, se, ec});
  endtask

  // Apply one pattern pair for n clocks; sample #1 after the last edge
  task automatic step(input logic [2:0] l, input logic [2:0] r, input logic clr, input int n);
    for (int i = 0; i < n; i++) begin
      left_p = l; right_p = r; err_clr = clr;
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    left_p = 3'b000; right_p = 3'b000; err_clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1 reset
    #1;
    expect_outs("reset_initial", 0, 0, 0, 0, 3'd0);
    do_reset();
    step(3'b001, 3'b000, 0, 2);
    expect_outs("pre_reset_turn", 1, 0, 0, 0, 3'd0);
    rst_n = 1'b0; #1;
    expect_outs("async_reset", 0, 0, 0, 0, 3'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(3'b000, 3'b000, 0, 3);
    expect_outs("reset_release", 0, 0, 0, 0, 3'd0);

    // 2 left turn, two rounds
    do_reset();
    step(3'b001, 3'b000, 0, 1);
    expect_outs("turn_first001", 1, 0, 0, 0, 3'd0);
    step(3'b001, 3'b000, 0, 4);
    step(3'b011, 3'b000, 0, 5);
    step(3'b111, 3'b000, 0, 5);
    step(3'b000, 3'b000, 0, 5);
    expect_outs("turn_round1_end", 1, 0, 0, 0, 3'd0);
    step(3'b001, 3'b000, 0, 5);
    step(3'b011, 3'b000, 0, 5);
    step(3'b111, 3'b000, 0, 5);
    step(3'b000, 3'b000, 0, 5);
    expect_outs("turn_000x5_hold", 1, 0, 0, 0, 3'd0);
    step(3'b000, 3'b000, 0, 1);
    expect_outs("turn_000x6_drop", 0, 0, 0, 0, 3'd0);

    // 3 steady brake
    do_reset();
    step(3'b111, 3'b111, 0, 5);
    expect_outs("brake_5th", 0, 0, 0, 0, 3'd0);
    step(3'b111, 3'b111, 0, 1);
    expect_outs("brake_6th", 0, 0, 1, 0, 3'd0);
    step(3'b111, 3'b111, 0, 2);
    expect_outs("brake_8th", 0, 0, 1, 0, 3'd0);
    step(3'b000, 3'b000, 0, 1);
    expect_outs("brake_release", 0, 0, 0, 0, 3'd0);

    // 4 right turn while braking
    do_reset();
    step(3'b111, 3'b111, 0, 5);
    step(3'b111, 3'b110, 0, 1);
    expect_outs("rturn_b2", 0, 1, 1, 0, 3'd0);
    step(3'b111, 3'b110, 0, 4);
    step(3'b111, 3'b100, 0, 5);
    step(3'b111, 3'b000, 0, 5);
    expect_outs("rturn_b4_end", 0, 1, 1, 0, 3'd0);
    step(3'b111, 3'b000, 0, 1);
    expect_outs("rturn_done_brake", 0, 0, 1, 0, 3'd0);
    step(3'b000, 3'b000, 0, 1);
    expect_outs("rturn_all_off", 0, 0, 0, 0, 3'd0);

    // 5 error codes
    do_reset();
    step(3'b001, 3'b000, 0, 3);
    expect_outs("err_t1_short_pre", 1, 0, 0, 0, 3'd0);
    step(3'b011, 3'b000, 0, 1);
    expect_outs("err_short", 0, 0, 0, 1, 3'd3);
    step(3'b000, 3'b000, 1, 1);
    expect_outs("err_clr", 0, 0, 0, 0, 3'd0);
    step(3'b010, 3'b000, 0, 1);
    expect_outs("err_illegal", 0, 0, 0, 1, 3'd1);
    step(3'b000, 3'b000, 1, 1);
    step(3'b001, 3'b001, 0, 1);
    expect_outs("err_cross", 1, 1, 0, 1, 3'd5);
    step(3'b000, 3'b000, 1, 1);
    expect_outs("err_cross_clr", 0, 0, 0, 0, 3'd0);
    step(3'b001, 3'b000, 0, 5);
    expect_outs("err_long_pre", 1, 0, 0, 0, 3'd0);
    step(3'b001, 3'b000, 0, 2);
    expect_outs("err_long", 0, 0, 0, 1, 3'd4);
    step(3'b010, 3'b000, 1, 1);
    expect_outs("err_clr_and_new", 0, 0, 0, 1, 3'd1);
    step(3'b000, 3'b011, 0, 1);
    expect_outs("err_first_kept", 0, 0, 0, 1, 3'd1);

    // 6 aborts are legal
    do_reset();
    step(3'b001, 3'b000, 0, 5);
    step(3'b111, 3'b000, 0, 1);
    expect_outs("abort_to_on", 0, 0, 0, 0, 3'd0);
    step(3'b000, 3'b000, 0, 1);
    step(3'b001, 3'b000, 0, 2);
    expect_outs("abort_early_pre", 1, 0, 0, 0, 3'd0);
    step(3'b000, 3'b000, 0, 1);
    expect_outs("abort_early_off", 0, 0, 0, 0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
